pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers. Handles load-use stalls, taken-branch flushes and multi-cycle MUL/DIV occupancy of EX. Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush
// sequencer. The slave side is the sequencer; the master side drives the
// hazard-detection inputs and observes the enables/flushes.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [REG_W-1:0] ex_rd_i;
    logic             ex_mdu_i;
    logic             branch_taken_i;
    logic             stat_clr_i;

    logic             pc_write_o;
    logic             ifid_write_o;
    logic             idex_write_o;
    logic             exmem_write_o;
    logic             memwb_write_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             exmem_flush_o;
    logic             mdu_busy_o;
    logic [15:0]      stall_cnt_o;

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
               ex_mdu_i, branch_taken_i, stat_clr_i,
        output pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
               memwb_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
               mdu_busy_o, stall_cnt_o
    );

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
               ex_mdu_i, branch_taken_i, stat_clr_i,
        input  pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
               memwb_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
               mdu_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle MUL/DIV freeze of EX and a saturating
// stall-cycle counter for performance debug.
module pipe_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 4,   // total EX occupancy of a MUL/DIV, 2..15
    parameter int CNT_W   = 4    // must hold MDU_LAT-1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {
        S_RUN,
        S_MDU_WAIT
    } state_t;

    localparam logic [REG_W-1:0] ZERO_REG  = '0;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [15:0]      r_stall_cnt;

    logic w_load_use;
    logic w_pc_write, w_ifid_write, w_idex_write, w_exmem_write, w_memwb_write;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_mdu_busy;

    // Load-use hazard: EX holds a load whose non-zero destination is read in ID.
    assign w_load_use = bus.ex_memread_i && (bus.ex_rd_i != ZERO_REG) &&
                        ((bus.ex_rd_i == bus.id_rs_i) ||
                         (bus.id_uses_rt_i && (bus.ex_rd_i == bus.id_rt_i)));

    // State and MDU down-counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and enable/flush decode; reset forces every control low.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_write  = 1'b1;
        w_exmem_write = 1'b1;
        w_memwb_write = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_mdu_busy    = 1'b0;

        case (r_state)
            S_RUN: begin
                if (bus.ex_mdu_i) begin
                    // Freeze front of pipe, push bubbles behind the MDU op.
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_write  = 1'b0;
                    w_exmem_flush = 1'b1;
                    w_mdu_busy    = 1'b1;
                    w_state_next  = S_MDU_WAIT;
                    w_cnt_next    = CNT_START;
                end else if (bus.branch_taken_i) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_idex_flush = 1'b1;
                end
            end
            S_MDU_WAIT: begin
                if (r_cnt > CNT_ONE) begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_write  = 1'b0;
                    w_exmem_flush = 1'b1;
                    w_mdu_busy    = 1'b1;
                    w_cnt_next    = r_cnt - CNT_ONE;
                end else begin
                    // Release cycle: result leaves EX, nothing else evaluated.
                    w_state_next = S_RUN;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = S_RUN;
                w_cnt_next   = '0;
            end
        endcase

        if (rst_i) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_memwb_write = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_flush  = 1'b0;
            w_exmem_flush = 1'b0;
            w_mdu_busy    = 1'b0;
        end
    end

    // Saturating count of cycles where the PC is held; clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (bus.stat_clr_i) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.pc_write_o    = w_pc_write;
    assign bus.ifid_write_o  = w_ifid_write;
    assign bus.idex_write_o  = w_idex_write;
    assign bus.exmem_write_o = w_exmem_write;
    assign bus.memwb_write_o = w_memwb_write;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_flush_o  = w_idex_flush;
    assign bus.exmem_flush_o = w_exmem_flush;
    assign bus.mdu_busy_o    = w_mdu_busy;
    assign bus.stall_cnt_o   = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
    localparam int REG_W   = 5;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;

    // Control vector order: pc, ifid, idex, exmem, memwb writes,
    // ifid, idex, exmem flushes, mdu_busy.
    localparam logic [8:0] V_NORMAL = 9'b11111_000_0;
    localparam logic [8:0] V_BRANCH = 9'b11111_110_0;
    localparam logic [8:0] V_LDUSE  = 9'b00111_010_0;
    localparam logic [8:0] V_FROZEN = 9'b00011_001_1;
    localparam logic [8:0] V_RESET  = 9'b00000_000_0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(REG_W)) bus ();

    pipe_hazard_ctrl #(.REG_W(REG_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [8:0] obs_w;
    assign obs_w = {bus.pc_write_o, bus.ifid_write_o, bus.idex_write_o,
                    bus.exmem_write_o, bus.memwb_write_o, bus.ifid_flush_o,
                    bus.idex_flush_o, bus.exmem_flush_o, bus.mdu_busy_o};

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: frozen cycles still owed to a MUL/DIV, a pending
    // release cycle, and the stall count as a plain integer.
    int m_frozen_left = 0;
    bit m_release     = 1'b0;
    int m_cnt         = 0;

    function automatic logic [8:0] model_out();
        logic hazard;
        if (rst) return V_RESET;
        hazard = bus.ex_memread_i && (bus.ex_rd_i != 0) &&
                 ((bus.ex_rd_i == bus.id_rs_i) ||
                  (bus.id_uses_rt_i && (bus.ex_rd_i == bus.id_rt_i)));
        if (m_frozen_left > 0) return V_FROZEN;
        if (m_release)         return V_NORMAL;
        if (bus.ex_mdu_i)      return V_FROZEN;
        if (bus.branch_taken_i) return V_BRANCH;
        if (hazard)            return V_LDUSE;
        return V_NORMAL;
    endfunction

    task automatic model_reset();
        m_frozen_left = 0;
        m_release     = 1'b0;
        m_cnt         = 0;
    endtask

    task automatic model_advance(input logic [8:0] exp);
        if (rst) begin
            model_reset();
        end else begin
            if (bus.stat_clr_i) m_cnt = 0;
            else if (!exp[8] && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_frozen_left > 0) begin
                m_frozen_left = m_frozen_left - 1;
                if (m_frozen_left == 0) m_release = 1'b1;
            end else if (m_release) begin
                m_release = 1'b0;
            end else if (bus.ex_mdu_i) begin
                m_frozen_left = MDU_LAT - 2;
                if (m_frozen_left == 0) m_release = 1'b1;
            end
        end
    endtask

    task automatic set_in(input logic ld, input int rd, input int rs, input int rt,
                          input logic urt, input logic mdu, input logic br,
                          input logic clr);
        bus.ex_memread_i   = ld;
        bus.ex_rd_i        = REG_W'(rd);
        bus.id_rs_i        = REG_W'(rs);
        bus.id_rt_i        = REG_W'(rt);
        bus.id_uses_rt_i   = urt;
        bus.ex_mdu_i       = mdu;
        bus.branch_taken_i = br;
        bus.stat_clr_i     = clr;
    endtask

    // One clock: sample at the falling edge, advance the model, return at
    // 1 time unit past the next rising edge so the caller can drive inputs.
    task automatic tick(input bit verbose, input string tag,
                        output logic [8:0] obs, output logic [8:0] exp,
                        output logic [15:0] cobs, output logic [15:0] cexp);
        @(negedge clk);
        if (rst) model_reset();
        exp  = model_out();
        obs  = obs_w;
        cobs = bus.stall_cnt_o;
        cexp = 16'(m_cnt);
        model_advance(exp);
        if (verbose)
            $display("%s: rst=%0b ld=%0b rd=%0d rs=%0d rt=%0d urt=%0b mdu=%0b br=%0b clr=%0b -> ctl=%b (want %b) cnt=%0d (want %0d)",
                     tag, rst, bus.ex_memread_i, bus.ex_rd_i, bus.id_rs_i, bus.id_rt_i,
                     bus.id_uses_rt_i, bus.ex_mdu_i, bus.branch_taken_i, bus.stat_clr_i,
                     obs, exp, cobs, cexp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] o, e;
        logic [15:0] co, ce;
        rst = 1'b1;
        set_in(1, 8, 8, 0, 0, 0, 0, 0);
        tick(1, "reset", o, e, co, ce);
        if (o !== V_RESET) begin
            $display("FAIL reset_ctl got %b want %b", o, V_RESET); n_err++;
        end
        n_vec++;
        if (co !== 16'd0) begin
            $display("FAIL reset_cnt got %0d want 0", co); n_err++;
        end
        n_vec++;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1, "idle", o, e, co, ce);
            if (o !== e || co !== ce) begin
                $display("FAIL idle ctl %b/%0d want %b/%0d", o, co, e, ce); n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_load_use();
        logic [8:0] o, e;
        logic [15:0] co, ce;
        int tbl [7][5] = '{'{1, 8, 8, 0, 0}, '{0, 8, 8, 0, 0}, '{1, 0, 0, 0, 1},
                           '{1, 8, 3, 8, 0}, '{1, 8, 3, 8, 1}, '{1, 5, 5, 5, 1},
                           '{0, 0, 0, 0, 0}};
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i][0][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4][0], 0, 0, 0);
            tick(1, "load_use", o, e, co, ce);
            if (o !== e) begin
                $display("FAIL load_use[%0d] ctl got %b want %b", i, o, e); n_err++;
            end
            n_vec++;
            if (co !== ce) begin
                $display("FAIL load_use_cnt[%0d] got %0d want %0d", i, co, ce); n_err++;
            end
            n_vec++;
        end
        if (co !== 16'd3) begin
            $display("FAIL load_use_total got %0d want 3", co); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_mdu(input bit with_hazards);
        logic [8:0] o, e;
        logic [15:0] co, ce, c0;
        int busy_seen = 0;
        c0 = bus.stall_cnt_o;
        for (int i = 0; i < MDU_LAT + 2; i++) begin
            if (i < MDU_LAT)
                set_in(with_hazards, 7, 7, 0, 0, 1, with_hazards && i > 0, 0);
            else
                set_in(0, 0, 0, 0, 0, 0, 0, 0);
            tick(1, with_hazards ? "mdu_hz" : "mdu", o, e, co, ce);
            if (o !== e) begin
                $display("FAIL mdu[%0d] ctl got %b want %b", i, o, e); n_err++;
            end
            n_vec++;
            if (co !== ce) begin
                $display("FAIL mdu_cnt[%0d] got %0d want %0d", i, co, ce); n_err++;
            end
            n_vec++;
            if (o[0]) busy_seen++;
        end
        if (busy_seen != MDU_LAT - 1) begin
            $display("FAIL mdu_frozen_cycles got %0d want %0d", busy_seen, MDU_LAT - 1); n_err++;
        end
        n_vec++;
        if (co - c0 !== 16'(MDU_LAT - 1)) begin
            $display("FAIL mdu_stalls got %0d want %0d", co - c0, MDU_LAT - 1); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_branch();
        logic [8:0] o, e;
        logic [15:0] co, ce;
        set_in(1, 9, 9, 9, 1, 0, 1, 0);
        tick(1, "branch_ld", o, e, co, ce);
        if (o !== V_BRANCH) begin
            $display("FAIL branch_over_load got %b want %b", o, V_BRANCH); n_err++;
        end
        n_vec++;
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        tick(1, "branch", o, e, co, ce);
        if (o !== e) begin
            $display("FAIL branch ctl got %b want %b", o, e); n_err++;
        end
        n_vec++;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_mdu();
        logic [8:0] o, e;
        logic [15:0] co, ce;
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        tick(1, "mdu_rst", o, e, co, ce);
        rst = 1'b1;
        tick(1, "mdu_rst", o, e, co, ce);
        if (o !== V_RESET || co !== 16'd0) begin
            $display("FAIL mid_mdu_reset ctl %b cnt %0d want %b cnt 0", o, co, V_RESET); n_err++;
        end
        n_vec++;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, "after_rst", o, e, co, ce);
        if (o !== V_NORMAL) begin
            $display("FAIL after_reset_run got %b want %b", o, V_NORMAL); n_err++;
        end
        n_vec++;
        set_in(1, 4, 4, 0, 0, 0, 0, 0);
        tick(1, "after_rst_ld", o, e, co, ce);
        if (o !== V_LDUSE) begin
            $display("FAIL after_reset_load got %b want %b", o, V_LDUSE); n_err++;
        end
        n_vec++;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [8:0] o, e;
        logic [15:0] co, ce;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) == 0);
            set_in($urandom_range(1), $urandom_range(3), $urandom_range(3),
                   $urandom_range(3), $urandom_range(1),
                   $urandom_range(7) == 0, $urandom_range(4) == 0,
                   $urandom_range(19) == 0);
            tick(1, "random", o, e, co, ce);
            if (o !== e) begin
                $display("FAIL random[%0d] ctl got %b want %b", i, o, e); n_err++;
            end
            n_vec++;
            if (co !== ce) begin
                $display("FAIL random_cnt[%0d] got %0d want %0d", i, co, ce); n_err++;
            end
            n_vec++;
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MDU_LAT; i++) tick(0, "drain", o, e, co, ce);
    endtask

    task automatic test_saturate();
        logic [8:0] o, e;
        logic [15:0] co, ce;
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick(1, "sat_clr", o, e, co, ce);
        set_in(1, 6, 6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) tick(0, "sat", o, e, co, ce);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, "sat_hold", o, e, co, ce);
        if (co !== 16'hFFFF || co !== ce) begin
            $display("FAIL saturate got %h want ffff (model %h)", co, ce); n_err++;
        end
        n_vec++;
        set_in(1, 6, 6, 0, 0, 0, 0, 1);
        tick(1, "clr_vs_stall", o, e, co, ce);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, "after_clr", o, e, co, ce);
        if (co !== 16'd0 || co !== ce) begin
            $display("FAIL stat_clr got %h want 0 (model %h)", co, ce); n_err++;
        end
        n_vec++;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_mdu(1'b0);
        test_mdu(1'b1);
        test_branch();
        test_reset_mid_mdu();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
